// File: rtl/dma_copy_ctrl.sv
// dma_copy_ctrl: control and data-move stage in front of the DMAC wrapper.
// A go pulse launches a host read and a host write of `size` words through
// the DMAC side-band. Words are then moved from the DMAC read FIFO to the
// DMAC write FIFO through a one-word skid register.
//
// Ports:
//   clk, rst_n          single clock, synchronous active-low reset
//   go                  one-cycle start request (ignored unless idle)
//   src_addr, dst_addr  source/destination offsets, sampled on accepted go
//   size                transfer length in words, sampled on accepted go
//   busy, done          status: busy until completion, done pulses once
//   words_copied        words pushed in the current or last transfer
//   rd_go/rd_size/rd_addr, rd_data/empty/rd_en/rd_done   DMAC read side
//   wr_go/wr_size/wr_addr, wr_data/full/wr_en/wr_done    DMAC write side
module dma_copy_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned SIZE_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  go,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [SIZE_WIDTH-1:0] size,
  output logic                  busy,
  output logic                  done,
  output logic [SIZE_WIDTH-1:0] words_copied,
  output logic                  rd_go,
  output logic [SIZE_WIDTH-1:0] rd_size,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  empty,
  output logic                  rd_en,
  input  logic                  rd_done,
  output logic                  wr_go,
  output logic [SIZE_WIDTH-1:0] wr_size,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  full,
  output logic                  wr_en,
  input  logic                  wr_done
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    COPY,
    DRAIN,
    DONE
  } state_t;

  state_t                state;
  logic [SIZE_WIDTH-1:0] size_q;
  logic [SIZE_WIDTH-1:0] rd_cnt;
  logic [SIZE_WIDTH-1:0] wc_next;
  logic                  skid_valid;
  logic                  rd_seen;
  logic                  wr_seen;
  logic                  pop;
  logic                  push;

  // Pop may refill the skid in the same cycle it is being emptied, which
  // gives one word per cycle when neither FIFO stalls.
  always_comb begin
    push    = 1'b0;
    pop     = 1'b0;
    wc_next = words_copied + 1'b1;
    if (state == COPY) begin
      push = skid_valid && !full;
      pop  = !empty && (rd_cnt < size_q) && (!skid_valid || push);
    end
    rd_en = pop;
    wr_en = push;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      words_copied <= '0;
      rd_go        <= 1'b0;
      wr_go        <= 1'b0;
      rd_size      <= '0;
      wr_size      <= '0;
      rd_addr      <= '0;
      wr_addr      <= '0;
      wr_data      <= '0;
      size_q       <= '0;
      rd_cnt       <= '0;
      skid_valid   <= 1'b0;
      rd_seen      <= 1'b0;
      wr_seen      <= 1'b0;
    end else begin
      rd_go <= 1'b0;
      wr_go <= 1'b0;
      done  <= 1'b0;

      // DMAC completions may arrive any time after launch; keep them sticky
      // so DRAIN never misses an early one.
      if (state == START || state == COPY || state == DRAIN) begin
        if (rd_done) rd_seen <= 1'b1;
        if (wr_done) wr_seen <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (go) begin
            size_q       <= size;
            rd_size      <= size;
            wr_size      <= size;
            rd_addr      <= src_addr;
            wr_addr      <= dst_addr;
            words_copied <= '0;
            rd_cnt       <= '0;
            skid_valid   <= 1'b0;
            rd_seen      <= 1'b0;
            wr_seen      <= 1'b0;
            busy         <= 1'b1;
            state        <= (size == '0) ? DONE : START;
          end
        end
        START: begin
          rd_go <= 1'b1;
          wr_go <= 1'b1;
          state <= COPY;
        end
        COPY: begin
          if (pop) begin
            wr_data    <= rd_data;
            rd_cnt     <= rd_cnt + 1'b1;
            skid_valid <= 1'b1;
          end else if (push) begin
            skid_valid <= 1'b0;
          end
          if (push) begin
            words_copied <= wc_next;
            if (wc_next == size_q) state <= DRAIN;
          end
        end
        DRAIN: begin
          if ((rd_seen || rd_done) && (wr_seen || wr_done)) state <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_copy_ctrl.sv
// Self-checking bench for dma_copy_ctrl. A read-FIFO model feeds the DUT;
// words due at the write FIFO are queued when loaded and compared on push.
module tb_dma_copy_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] size = '0;
  logic        busy, done;
  logic [15:0] words_copied;
  logic        rd_go, wr_go;
  logic [15:0] rd_size, wr_size;
  logic [31:0] rd_addr, wr_addr;
  logic [31:0] rd_data = '0;
  logic        empty = 1'b1;
  logic        rd_en;
  logic        rd_done = 1'b0;
  logic [31:0] wr_data;
  logic        full = 1'b0;
  logic        wr_en;
  logic        wr_done = 1'b0;

  dma_copy_ctrl #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .SIZE_WIDTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .go(go),
    .src_addr(src_addr), .dst_addr(dst_addr), .size(size),
    .busy(busy), .done(done), .words_copied(words_copied),
    .rd_go(rd_go), .rd_size(rd_size), .rd_addr(rd_addr),
    .rd_data(rd_data), .empty(empty), .rd_en(rd_en), .rd_done(rd_done),
    .wr_go(wr_go), .wr_size(wr_size), .wr_addr(wr_addr),
    .wr_data(wr_data), .full(full), .wr_en(wr_en), .wr_done(wr_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] src_q[$];
  logic [31:0] exp_q[$];

  int  push_cnt = 0, pop_cnt = 0, rdgo_cnt = 0, wrgo_cnt = 0, done_cnt = 0;
  int  cyc = 0, first_push_cyc = -1, last_push_cyc = -1;
  int  full_mode = 0;   // 0: never full, 1: toggles every cycle
  bit  rand_empty = 0, hold_empty = 0, occ = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // FIFO model: drive at negedge, observe the DUT's pop/push decisions after
  // the main process has updated its own inputs for the cycle.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      full    = (full_mode == 1) ? ~full : 1'b0;
      empty   = hold_empty || (src_q.size() == 0) || (rand_empty && ($urandom_range(0, 1) == 1));
      rd_data = (src_q.size() != 0) ? src_q[0] : '0;
      #3;
      if (rst_n) begin
        if (rd_go) rdgo_cnt++;
        if (wr_go) wrgo_cnt++;
        if (done)  done_cnt++;
        if (wr_en) begin
          check("push_while_full", {63'd0, full}, 64'd0);
          if (exp_q.size() == 0) check("unexpected_push", 64'd1, 64'd0);
          else check("wr_data", {32'd0, wr_data}, {32'd0, exp_q.pop_front()});
          push_cnt++;
          if (first_push_cyc < 0) first_push_cyc = cyc;
          last_push_cyc = cyc;
        end
        if (rd_en) begin
          check("pop_into_held_skid", {63'd0, occ && !wr_en}, 64'd0);
          if (src_q.size() != 0) void'(src_q.pop_front());
          pop_cnt++;
        end
        occ = rd_en ? 1'b1 : (wr_en ? 1'b0 : occ);
      end else begin
        occ = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic load(input int n, input int extra);
    logic [31:0] w;
    for (int i = 0; i < n + extra; i++) begin
      w = $urandom;
      src_q.push_back(w);
      if (i < n) exp_q.push_back(w);
    end
  endtask

  task automatic start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    go = 1'b1; src_addr = s; dst_addr = d; size = n;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_pushes(input int target, input int max_cyc);
    bit ok = 0;
    for (int i = 0; i < max_cyc; i++) begin
      if (push_cnt >= target) begin ok = 1; break; end
      tick();
    end
    if (!ok) check("push_timeout", 64'(push_cnt), 64'(target));
  endtask

  task automatic wait_done(input int max_cyc);
    bit ok = 0;
    for (int i = 0; i < max_cyc; i++) begin
      if (done) begin ok = 1; break; end
      tick();
    end
    if (!ok) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic pulse_both_done();
    rd_done = 1'b1; wr_done = 1'b1;
    tick();
    rd_done = 1'b0; wr_done = 1'b0;
  endtask

  int base_push, base_pop, base_rdgo, base_wrgo, base_done;

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_rdgo", {63'd0, rd_go}, 64'd0);
    check("rst_wc", 64'(words_copied), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic size=4 transfer, two extra words left in the read FIFO
    load(4, 2);
    first_push_cyc = -1;
    start(32'h100, 32'h200, 16'd4);
    check("t1_rdgo_early", {63'd0, rd_go}, 64'd0);
    check("t1_busy", {63'd0, busy}, 64'd1);
    tick();
    check("t1_rdgo", {62'd0, rd_go, wr_go}, 64'd3);
    check("t1_rd_addr", 64'(rd_addr), 64'h100);
    check("t1_wr_addr", 64'(wr_addr), 64'h200);
    check("t1_sizes", {32'd0, rd_size, wr_size}, {32'd0, 16'd4, 16'd4});
    tick();
    check("t1_rdgo_1cyc", {62'd0, rd_go, wr_go}, 64'd0);
    wait_pushes(4, 50);
    check("t1_back_to_back", 64'(last_push_cyc - first_push_cyc), 64'd3);
    base_done = done_cnt;
    pulse_both_done();
    wait_done(10);
    tick();
    check("t1_done_once", 64'(done_cnt - base_done), 64'd1);
    check("t1_wc", 64'(words_copied), 64'd4);
    check("t1_busy_end", {63'd0, busy}, 64'd0);
    check("t1_extra_kept", 64'(src_q.size()), 64'd2);
    check("t1_exp_empty", 64'(exp_q.size()), 64'd0);
    src_q.delete();

    // size=0: completes with no DMAC activity
    base_push = push_cnt; base_pop = pop_cnt; base_rdgo = rdgo_cnt; base_wrgo = wrgo_cnt;
    start(32'h5, 32'h6, 16'd0);
    check("t2_busy", {63'd0, busy}, 64'd1);
    check("t2_done_early", {63'd0, done}, 64'd0);
    tick();
    check("t2_done", {63'd0, done}, 64'd1);
    check("t2_busy_end", {63'd0, busy}, 64'd0);
    check("t2_wc", 64'(words_copied), 64'd0);
    tick();
    check("t2_done_pulse", {63'd0, done}, 64'd0);
    check("t2_no_activity", 64'((push_cnt - base_push) + (pop_cnt - base_pop) +
          (rdgo_cnt - base_rdgo) + (wrgo_cnt - base_wrgo)), 64'd0);

    // size=8 with full toggling and random empty
    load(8, 3);
    full_mode = 1; rand_empty = 1;
    base_push = push_cnt; base_pop = pop_cnt;
    start(32'h40, 32'h80, 16'd8);
    wait_pushes(base_push + 8, 300);
    pulse_both_done();
    wait_done(10);
    full_mode = 0; rand_empty = 0;
    tick();
    check("t3_pushes", 64'(push_cnt - base_push), 64'd8);
    check("t3_pops", 64'(pop_cnt - base_pop), 64'd8);
    check("t3_wc", 64'(words_copied), 64'd8);
    check("t3_extra_kept", 64'(src_q.size()), 64'd3);
    check("t3_exp_empty", 64'(exp_q.size()), 64'd0);
    src_q.delete();

    // Early wr_done during COPY, rd_done only after the last push
    load(5, 0);
    full_mode = 1;
    base_push = push_cnt;
    start(32'h1000, 32'h2000, 16'd5);
    wait_pushes(base_push + 1, 100);
    wr_done = 1'b1; tick(); wr_done = 1'b0;
    wait_pushes(base_push + 5, 100);
    full_mode = 0;
    repeat (3) tick();
    check("t4_drain_wait_done", {63'd0, done}, 64'd0);
    check("t4_drain_busy", {63'd0, busy}, 64'd1);
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    check("t4_done_not_yet", {63'd0, done}, 64'd0);
    tick();
    check("t4_done", {63'd0, done}, 64'd1);
    check("t4_wc", 64'(words_copied), 64'd5);

    // Reset after the 3rd push of a size=6 transfer
    tick();
    load(6, 0);
    base_push = push_cnt;
    start(32'h10, 32'h20, 16'd6);
    wait_pushes(base_push + 3, 100);
    rst_n = 1'b0;
    tick();
    check("t5_rst_ctrl", {58'd0, busy, done, rd_go, wr_go, rd_en, wr_en}, 64'd0);
    check("t5_rst_wc", 64'(words_copied), 64'd0);
    check("t5_rst_sizes", {32'd0, rd_size, wr_size}, 64'd0);
    check("t5_rst_addrs", {rd_addr, wr_addr}, 64'd0);
    check("t5_rst_wr_data", 64'(wr_data), 64'd0);
    check("t5_no_push_after", 64'(push_cnt - base_push), 64'd3);
    rst_n = 1'b1;
    src_q.delete(); exp_q.delete();
    tick();
    load(2, 0);
    base_push = push_cnt;
    start(32'h30, 32'h50, 16'd2);
    wait_pushes(base_push + 2, 50);
    pulse_both_done();
    wait_done(10);
    check("t5_wc", 64'(words_copied), 64'd2);
    check("t5_exp_empty", 64'(exp_q.size()), 64'd0);

    // go while busy is ignored
    tick();
    hold_empty = 1;
    load(3, 0);
    base_push = push_cnt;
    start(32'h300, 32'h400, 16'd3);
    tick();
    tick();
    base_rdgo = rdgo_cnt;
    go = 1'b1; src_addr = 32'h999; dst_addr = 32'hAAA; size = 16'd7;
    tick();
    go = 1'b0;
    repeat (3) tick();
    check("t6_rd_addr", 64'(rd_addr), 64'h300);
    check("t6_wr_addr", 64'(wr_addr), 64'h400);
    check("t6_size", {32'd0, rd_size, wr_size}, {32'd0, 16'd3, 16'd3});
    check("t6_no_second_rdgo", 64'(rdgo_cnt - base_rdgo), 64'd0);
    hold_empty = 0;
    wait_pushes(base_push + 3, 50);
    pulse_both_done();
    wait_done(10);
    check("t6_wc", 64'(words_copied), 64'd3);
    check("t6_pushes", 64'(push_cnt - base_push), 64'd3);

    tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
